// File: rtl/fpacc_seq_if.sv
// Handshake bundle for fpacc_seq: element stream in, fpadd start/done link, frame total out.
// master is the sequencer side; slave is the surrounding datapath (operand buffer, fpadd, writeback).
interface fpacc_seq_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic             add_start;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             add_done;
  logic             out_valid;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ready;
  logic             busy;
  logic             err;

  modport master (
    input  in_valid, in_data, in_last, add_sum, add_done, out_ready,
    output in_ready, add_start, add_a, add_b, out_valid, out_sum, out_count, busy, err
  );

  modport slave (
    output in_valid, in_data, in_last, add_sum, add_done, out_ready,
    input  in_ready, add_start, add_a, add_b, out_valid, out_sum, out_count, busy, err
  );
endinterface

// File: rtl/fpacc_seq.sv
// Streaming FP32 accumulation sequencer driving one fpadd over a start/done handshake.
// Optional add_done timeout with sticky err is enabled by defining FPACC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for an element; first element of a frame loads acc directly
// ISSUE | add_start pulse with add_a/add_b held
// GUARD | dead cycle so a stale add_done from the previous op is never sampled
// WAIT  | waiting for add_done, then acc <= add_sum
// OUT   | frame total presented until out_ready
module fpacc_seq #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic         clk,
  input logic         reset,
  fpacc_seq_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] GUARD = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("fpacc_seq: TIMEOUT_CYCLES must be at least 2");
  end

  logic [2:0]       state;
  logic [31:0]      acc;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [CNT_W-1:0] count;
  logic             last_q;
  logic             first;
  logic             tmo;

  // in_ready is also gated by reset so it reads 0 while reset is held
  assign bus.in_ready  = (state == IDLE) && reset;
  assign bus.add_start = (state == ISSUE);
  assign bus.add_a     = op_a;
  assign bus.add_b     = op_b;
  assign bus.out_valid = (state == OUT);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      count  <= '0;
      last_q <= 1'b0;
      first  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            last_q <= bus.in_last;
            if (first) begin
              acc   <= bus.in_data;
              count <= CNT_W'(1);
              first <= 1'b0;
              if (bus.in_last) state <= OUT;
            end else begin
              op_a  <= acc;
              op_b  <= bus.in_data;
              count <= (count == CNT_MAX) ? count : count + CNT_W'(1);
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= GUARD;
        GUARD: state <= WAIT;
        WAIT: begin
          if (bus.add_done) begin
            acc   <= bus.add_sum;
            state <= last_q ? OUT : IDLE;
          end else if (tmo) begin
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            first <= 1'b1;
            count <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPACC_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr;
  logic             err_q;

  // Loaded in ISSUE, held in GUARD, counts in WAIT: reaches zero TIMEOUT_CYCLES after the start cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ISSUE) tmr <= TMR_W'(TIMEOUT_CYCLES - 2);
      else if (state == WAIT && tmr != '0) tmr <= tmr - TMR_W'(1);
      if (tmo) err_q <= 1'b1;
    end
  end

  assign tmo     = (state == WAIT) && !bus.add_done && (tmr == '0);
  assign bus.err = err_q;
`else
  assign tmo     = 1'b0;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_fpacc_seq.sv
// Randomized bench for fpacc_seq with an integer-valued fpadd model and frame-sum reference.
module tb_fpacc_seq;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpacc_seq_if #(.CNT_W(CNT_W)) bus ();

  fpacc_seq #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int lat = 5;
  bit stale_mode = 0;
  bit no_done = 0;
  bit aborted = 0;
  int starts = 0;
  logic [63:0] exp_ops[$];
  logic [31:0] frame_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Exact for non-negative integers below 2^24
  function automatic logic [31:0] int2fp(input int n);
    int p;
    logic [31:0] m;
    if (n <= 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if (n >= (1 << i)) p = i;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int fp2int(input logic [31:0] f);
    int e;
    logic [31:0] mant;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    mant = {8'h0, 1'b1, f[22:0]};
    return int'(mant >> (23 - e));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return int2fp(fp2int(a) + fp2int(b));
  endfunction

  // fpadd model: done clears on the edge after start (one cycle later in stale mode)
  initial begin
    int age;
    int olat;
    bit pend;
    logic [31:0] ea, eb, ca, cb;
    logic [63:0] op;
    bus.add_done = 1'b0;
    bus.add_sum  = 32'h0;
    pend = 0; age = 0; olat = 2;
    ea = 0; eb = 0; ca = 0; cb = 0;
    forever begin
      @(posedge clk); #1;
      if (pend) begin
        age++;
        if ((age == 1 && !stale_mode) || age == 2) bus.add_done = 1'b0;
        if (!no_done && age == olat) begin
          if (!aborted) begin
            chk("add_a_hold", bus.add_a, ea);
            chk("add_b_hold", bus.add_b, eb);
          end
          bus.add_sum  = fadd(ca, cb);
          bus.add_done = 1'b1;
          pend = 0;
        end
      end
      if (bus.add_start) begin
        starts++;
        chk("op_queue", exp_ops.size(), 1);
        if (exp_ops.size() > 0) begin
          op = exp_ops.pop_front();
          ea = op[63:32];
          eb = op[31:0];
        end
        chk("add_a", bus.add_a, ea);
        chk("add_b", bus.add_b, eb);
        ca = bus.add_a; cb = bus.add_b;
        pend = 1; age = 0; olat = lat; aborted = 0;
      end
    end
  end

  task automatic send_elem(input logic [31:0] d, input bit last);
    int w;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last; w = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    if (w == 500) chk("in_ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic collect(input logic [31:0] es, input int ec, input int est, input bit stall);
    int w, bad;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    chk("out_valid_wait", bus.out_valid, 1);
    if (stall) begin
      bus.in_valid = 1'b1; bus.in_data = int2fp(5); bus.in_last = 1'b1; bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== es) bad++;
      end
      chk("stall_hold", bad, 0);
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("out_sum", bus.out_sum, es);
    chk("out_count", bus.out_count, ec);
    chk("add_starts", starts, est);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_clear", bus.out_valid, 0);
  endtask

  task automatic run_frame(input bit stall);
    int n, total, ec;
    logic [31:0] es;
    n = frame_q.size(); total = 0; starts = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) exp_ops.push_back({int2fp(total), frame_q[i]});
      total += fp2int(frame_q[i]);
      send_elem(frame_q[i], i == n - 1);
      if (n == 1) chk("single_out_valid", bus.out_valid, 1);
      if (i < n - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    es = (n == 1) ? frame_q[0] : int2fp(total);
    ec = (n > CNT_MAX) ? CNT_MAX : n;
    collect(es, ec, n - 1, stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    #3;
    chk("rst_ctrl", {bus.busy, bus.out_valid, bus.in_ready, bus.add_start, bus.err}, 0);
    chk("rst_data", bus.add_a | bus.add_b | bus.out_sum, 0);
    chk("rst_count", bus.out_count, 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", bus.in_ready, 1);

    lat = 5;
    frame_q = {32'h3F800000, 32'h40000000};
    run_frame(0);

    frame_q = {32'h3F800000, 32'h40000000, 32'h40800000};
    run_frame(0);

    frame_q = {32'h40490FDB};
    run_frame(0);

    frame_q = {32'h3F800000, 32'h40000000};
    run_frame(1);
    chk("ready_after_xfer", bus.in_ready, 1);
    starts = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    collect(int2fp(5), 1, 0, 0);

    stale_mode = 1; lat = 3;
    frame_q = {int2fp(9), int2fp(10), int2fp(11)};
    run_frame(0);
    stale_mode = 0;

    lat = 30; starts = 0;
    exp_ops.push_back({32'h3F800000, 32'h40000000});
    send_elem(32'h3F800000, 0);
    send_elem(32'h40000000, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("pre_rst_busy", bus.busy, 1);
    aborted = 1;
    reset = 1'b0; #1;
    chk("rst_mid_ctrl", {bus.busy, bus.out_valid, bus.in_ready, bus.add_start, bus.err}, 0);
    chk("rst_mid_data", bus.add_a | bus.add_b | bus.out_sum, 0);
    chk("rst_mid_count", bus.out_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    lat = 5;
    @(posedge clk); #1;
    frame_q = {32'h3F800000};
    run_frame(0);

`ifdef FPACC_TIMEOUT_EN
    chk("err_before_tmo", bus.err, 0);
    no_done = 1; starts = 0;
    exp_ops.push_back({32'h3F800000, 32'h40000000});
    send_elem(32'h3F800000, 0);
    send_elem(32'h40000000, 1);
    collect(32'h3F800000, 2, 1, 0);
    chk("err_set", bus.err, 1);
    no_done = 0;
    frame_q = {int2fp(3), int2fp(4)};
    run_frame(0);
    chk("err_sticky", bus.err, 1);
`endif

    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 6);
      lat = $urandom_range(2, 8);
      stale_mode = bit'($urandom_range(0, 1));
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(int2fp($urandom_range(1, 1000)));
      run_frame(0);
    end
    stale_mode = 0;

    lat = 2;
    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back(int2fp($urandom_range(1, 1000)));
    run_frame(0);

`ifndef FPACC_TIMEOUT_EN
    chk("err_zero", bus.err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
